// File: rtl/id_ex_stage_reg.sv
// ---------------------------------------------------------------------------
// id_ex_stage_reg
//
// ID/EX pipeline register. It captures the control bundles produced by the
// ID-stage control unit, together with the ID-stage operands and register
// specifiers, and presents them to the EX stage. It also breaks the EX
// bundle into named control lines for the ALU path.
//
// The block detects load-use hazards against the instruction it currently
// holds. When a hazard is found it freezes the front end through stall_out
// and loads a bubble into the slot. A branch-taken flush from MEM empties
// the slot and takes priority over the hazard.
//
// Parameters:
//   DW - data path width for npc, read data and immediate
//   CW - width of the saturating bubble counter
//
// Ports:
//   clk, rst            - rising-edge clock, asynchronous active-high reset
//   wb_in  [1:0]        - {RegWrite, MemtoReg}
//   m_in   [2:0]        - {Branch, MemRead, MemWrite}
//   ex_in  [3:0]        - {RegDst, ALUOp[1:0], ALUSrc}
//   npc_in, rd1_in, rd2_in, imm_in [DW-1:0] - ID-stage operands
//   rs_in, rt_in, rd_in [4:0]               - ID-stage register specifiers
//   flush               - branch-taken flush from the MEM stage
//   wb_out, m_out, ex_out                   - registered bundles
//   npc_out, rd1_out, rd2_out, imm_out      - registered operands
//   rs_out, rt_out, rd_out                  - registered specifiers
//   reg_dst, alu_op, alu_src                - decoded from ex_out
//   valid_out           - slot holds a real instruction (not a bubble)
//   stall_out           - combinational; freezes the PC and IF/ID
//   stall_cnt [CW-1:0]  - saturating count of hazard bubbles
// ---------------------------------------------------------------------------
module id_ex_stage_reg #(
    parameter int DW = 32,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst,

    input  logic [1:0]    wb_in,
    input  logic [2:0]    m_in,
    input  logic [3:0]    ex_in,
    input  logic [DW-1:0] npc_in,
    input  logic [DW-1:0] rd1_in,
    input  logic [DW-1:0] rd2_in,
    input  logic [DW-1:0] imm_in,
    input  logic [4:0]    rs_in,
    input  logic [4:0]    rt_in,
    input  logic [4:0]    rd_in,
    input  logic          flush,

    output logic [1:0]    wb_out,
    output logic [2:0]    m_out,
    output logic [3:0]    ex_out,
    output logic [DW-1:0] npc_out,
    output logic [DW-1:0] rd1_out,
    output logic [DW-1:0] rd2_out,
    output logic [DW-1:0] imm_out,
    output logic [4:0]    rs_out,
    output logic [4:0]    rt_out,
    output logic [4:0]    rd_out,
    output logic          reg_dst,
    output logic          alu_src,
    output logic [1:0]    alu_op,
    output logic          valid_out,
    output logic          stall_out,
    output logic [CW-1:0] stall_cnt
);

    // Bit positions inside the bundles
    localparam int EX_REG_DST  = 3;
    localparam int EX_ALU_OP_H = 2;
    localparam int EX_ALU_OP_L = 1;
    localparam int EX_ALU_SRC  = 0;
    localparam int M_MEM_READ  = 1;

    localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

    // -----------------------------------------------------------------------
    // Registered state
    // -----------------------------------------------------------------------
    logic [1:0]    wb_q,    wb_d;
    logic [2:0]    m_q,     m_d;
    logic [3:0]    ex_q,    ex_d;
    logic [DW-1:0] npc_q,   npc_d;
    logic [DW-1:0] rd1_q,   rd1_d;
    logic [DW-1:0] rd2_q,   rd2_d;
    logic [DW-1:0] imm_q,   imm_d;
    logic [4:0]    rs_q,    rs_d;
    logic [4:0]    rt_q,    rt_d;
    logic [4:0]    rd_q,    rd_d;
    logic          valid_q, valid_d;
    logic [CW-1:0] cnt_q,   cnt_d;

    logic          haz;

    // Load-use hazard: the held instruction is a real load whose destination
    // (rt) is read by the instruction now in ID. $0 is hardwired to zero, so
    // a load targeting it cannot create a dependency.
    always_comb begin
        haz = valid_q
            & m_q[M_MEM_READ]
            & (rt_q != 5'd0)
            & ((rt_q == rs_in) | (rt_q == rt_in));
    end

    // A flush discards the instruction in ID anyway, so there is nothing to
    // hold back and the front end must keep moving.
    assign stall_out = haz & ~flush;

    // Next-state selection. Flush wins over the hazard; a hazard inserts a
    // bubble (control cleared, operands still captured so the slot contents
    // stay deterministic) and bumps the saturating counter.
    always_comb begin
        wb_d    = wb_in;
        m_d     = m_in;
        ex_d    = ex_in;
        npc_d   = npc_in;
        rd1_d   = rd1_in;
        rd2_d   = rd2_in;
        imm_d   = imm_in;
        rs_d    = rs_in;
        rt_d    = rt_in;
        rd_d    = rd_in;
        valid_d = 1'b1;
        cnt_d   = cnt_q;

        if (flush) begin
            wb_d    = '0;
            m_d     = '0;
            ex_d    = '0;
            npc_d   = '0;
            rd1_d   = '0;
            rd2_d   = '0;
            imm_d   = '0;
            rs_d    = '0;
            rt_d    = '0;
            rd_d    = '0;
            valid_d = 1'b0;
        end else if (haz) begin
            wb_d    = '0;
            m_d     = '0;
            ex_d    = '0;
            valid_d = 1'b0;
            if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Pipeline register with asynchronous clear of every field.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_q    <= '0;
            m_q     <= '0;
            ex_q    <= '0;
            npc_q   <= '0;
            rd1_q   <= '0;
            rd2_q   <= '0;
            imm_q   <= '0;
            rs_q    <= '0;
            rt_q    <= '0;
            rd_q    <= '0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            wb_q    <= wb_d;
            m_q     <= m_d;
            ex_q    <= ex_d;
            npc_q   <= npc_d;
            rd1_q   <= rd1_d;
            rd2_q   <= rd2_d;
            imm_q   <= imm_d;
            rs_q    <= rs_d;
            rt_q    <= rt_d;
            rd_q    <= rd_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign wb_out    = wb_q;
    assign m_out     = m_q;
    assign ex_out    = ex_q;
    assign npc_out   = npc_q;
    assign rd1_out   = rd1_q;
    assign rd2_out   = rd2_q;
    assign imm_out   = imm_q;
    assign rs_out    = rs_q;
    assign rt_out    = rt_q;
    assign rd_out    = rd_q;
    assign valid_out = valid_q;
    assign stall_cnt = cnt_q;

    assign reg_dst = ex_q[EX_REG_DST];
    assign alu_op  = ex_q[EX_ALU_OP_H:EX_ALU_OP_L];
    assign alu_src = ex_q[EX_ALU_SRC];

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// ---------------------------------------------------------------------------
// tb_id_ex_stage_reg
//
// Self-checking bench for id_ex_stage_reg. A directed vector table walks the
// R-type, load-use, $zero and flush cases. Hand-written sequences cover the
// asynchronous reset and counter saturation, and a randomized phase runs
// against a behavioural model of the slot. Two instances share the same
// inputs: one with the default counter width and one with CW = 2.
// ---------------------------------------------------------------------------
module tb_id_ex_stage_reg;

    localparam int DW = 32;

    logic          clk;
    logic          rst;
    logic [1:0]    wb_in;
    logic [2:0]    m_in;
    logic [3:0]    ex_in;
    logic [DW-1:0] npc_in, rd1_in, rd2_in, imm_in;
    logic [4:0]    rs_in, rt_in, rd_in;
    logic          flush;

    logic [1:0]    wb_out,  s_wb_out;
    logic [2:0]    m_out,   s_m_out;
    logic [3:0]    ex_out,  s_ex_out;
    logic [DW-1:0] npc_out, rd1_out, rd2_out, imm_out;
    logic [DW-1:0] s_npc_out, s_rd1_out, s_rd2_out, s_imm_out;
    logic [4:0]    rs_out, rt_out, rd_out, s_rs_out, s_rt_out, s_rd_out;
    logic          reg_dst, alu_src, valid_out, stall_out;
    logic          s_reg_dst, s_alu_src, s_valid_out, s_stall_out;
    logic [1:0]    alu_op, s_alu_op;
    logic [15:0]   stall_cnt;
    logic [1:0]    s_stall_cnt;

    id_ex_stage_reg #(.DW(DW), .CW(16)) dut (
        .clk(clk), .rst(rst),
        .wb_in(wb_in), .m_in(m_in), .ex_in(ex_in),
        .npc_in(npc_in), .rd1_in(rd1_in), .rd2_in(rd2_in), .imm_in(imm_in),
        .rs_in(rs_in), .rt_in(rt_in), .rd_in(rd_in), .flush(flush),
        .wb_out(wb_out), .m_out(m_out), .ex_out(ex_out),
        .npc_out(npc_out), .rd1_out(rd1_out), .rd2_out(rd2_out), .imm_out(imm_out),
        .rs_out(rs_out), .rt_out(rt_out), .rd_out(rd_out),
        .reg_dst(reg_dst), .alu_src(alu_src), .alu_op(alu_op),
        .valid_out(valid_out), .stall_out(stall_out), .stall_cnt(stall_cnt)
    );

    id_ex_stage_reg #(.DW(DW), .CW(2)) dut_sat (
        .clk(clk), .rst(rst),
        .wb_in(wb_in), .m_in(m_in), .ex_in(ex_in),
        .npc_in(npc_in), .rd1_in(rd1_in), .rd2_in(rd2_in), .imm_in(imm_in),
        .rs_in(rs_in), .rt_in(rt_in), .rd_in(rd_in), .flush(flush),
        .wb_out(s_wb_out), .m_out(s_m_out), .ex_out(s_ex_out),
        .npc_out(s_npc_out), .rd1_out(s_rd1_out), .rd2_out(s_rd2_out), .imm_out(s_imm_out),
        .rs_out(s_rs_out), .rt_out(s_rt_out), .rd_out(s_rd_out),
        .reg_dst(s_reg_dst), .alu_src(s_alu_src), .alu_op(s_alu_op),
        .valid_out(s_valid_out), .stall_out(s_stall_out), .stall_cnt(s_stall_cnt)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int nErrors = 0;
    int nChecks = 0;

    // Behavioural picture of what the slot holds
    typedef struct {
        logic [1:0]    wb;
        logic [2:0]    m;
        logic [3:0]    ex;
        logic [DW-1:0] npc, rd1, rd2, imm;
        logic [4:0]    rs, rt, rd;
        logic          valid;
    } slot_t;

    slot_t mv;
    int    cntDef;
    int    cntSat;

    // Directed vectors: inputs plus expected stall before the edge and the
    // expected slot contents after it.
    typedef struct {
        logic [1:0]  wb;
        logic [2:0]  m;
        logic [3:0]  ex;
        logic [4:0]  rs, rt;
        logic        fl;
        logic [31:0] rd1;
        logic        expStall;
        logic        expValid;
        logic [1:0]  expWb;
        logic [2:0]  expM;
        logic [3:0]  expEx;
        logic [31:0] expRd1;
        int          expCnt;
    } vec_t;

    vec_t vecs[9];

    function automatic vec_t mkVec(
        input logic [1:0] wb, input logic [2:0] m, input logic [3:0] ex,
        input logic [4:0] rs, input logic [4:0] rt, input logic fl,
        input logic [31:0] rd1, input logic expStall, input logic expValid,
        input logic [1:0] expWb, input logic [2:0] expM, input logic [3:0] expEx,
        input logic [31:0] expRd1, input int expCnt);
        vec_t v;
        v.wb = wb; v.m = m; v.ex = ex; v.rs = rs; v.rt = rt; v.fl = fl;
        v.rd1 = rd1; v.expStall = expStall; v.expValid = expValid;
        v.expWb = expWb; v.expM = expM; v.expEx = expEx;
        v.expRd1 = expRd1; v.expCnt = expCnt;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act,
                               input logic [63:0] exp);
        nChecks++;
        if (act !== exp) begin
            nErrors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] wb, input logic [2:0] m,
                                 input logic [3:0] ex, input logic [4:0] rs,
                                 input logic [4:0] rt, input logic [4:0] rd,
                                 input logic fl, input logic [31:0] rd1);
        wb_in  = wb;
        m_in   = m;
        ex_in  = ex;
        rs_in  = rs;
        rt_in  = rt;
        rd_in  = rd;
        flush  = fl;
        rd1_in = rd1;
        npc_in = $urandom;
        rd2_in = $urandom;
        imm_in = $urandom;
    endtask

    // A load sits in the slot and the instruction in ID reads its target
    function automatic logic modelHaz();
        return mv.valid && mv.m[1] && (mv.rt != 0) &&
               ((mv.rt == rs_in) || (mv.rt == rt_in));
    endfunction

    function automatic logic modelStall();
        return modelHaz() && !flush;
    endfunction

    task automatic modelReset();
        mv = '{default: '0};
        cntDef = 0;
        cntSat = 0;
    endtask

    // What the slot should contain after the coming edge
    task automatic modelEdge();
        logic h;
        h = modelHaz();
        if (flush) begin
            mv = '{default: '0};
        end else begin
            mv.wb = wb_in;  mv.m = m_in;  mv.ex = ex_in;
            mv.npc = npc_in; mv.rd1 = rd1_in; mv.rd2 = rd2_in; mv.imm = imm_in;
            mv.rs = rs_in;  mv.rt = rt_in;  mv.rd = rd_in;
            mv.valid = !h;
            if (h) begin
                mv.wb = '0; mv.m = '0; mv.ex = '0;
                cntDef = (cntDef < 65535) ? cntDef + 1 : 65535;
                cntSat = (cntSat < 3) ? cntSat + 1 : 3;
            end
        end
    endtask

    task automatic stepClock();
        modelEdge();
        @(posedge clk);
        #1;
    endtask

    task automatic checkAll();
        checkOutput("wb_out",    64'(wb_out),    64'(mv.wb));
        checkOutput("m_out",     64'(m_out),     64'(mv.m));
        checkOutput("ex_out",    64'(ex_out),    64'(mv.ex));
        checkOutput("npc_out",   64'(npc_out),   64'(mv.npc));
        checkOutput("rd1_out",   64'(rd1_out),   64'(mv.rd1));
        checkOutput("rd2_out",   64'(rd2_out),   64'(mv.rd2));
        checkOutput("imm_out",   64'(imm_out),   64'(mv.imm));
        checkOutput("rs_out",    64'(rs_out),    64'(mv.rs));
        checkOutput("rt_out",    64'(rt_out),    64'(mv.rt));
        checkOutput("rd_out",    64'(rd_out),    64'(mv.rd));
        checkOutput("valid_out", 64'(valid_out), 64'(mv.valid));
        checkOutput("reg_dst",   64'(reg_dst),   64'(mv.ex[3]));
        checkOutput("alu_op",    64'(alu_op),    64'(mv.ex[2:1]));
        checkOutput("alu_src",   64'(alu_src),   64'(mv.ex[0]));
        checkOutput("stall_out", 64'(stall_out), 64'(modelStall()));
        checkOutput("stall_cnt", 64'(stall_cnt), 64'(cntDef));
        checkOutput("sat_cnt",   64'(s_stall_cnt), 64'(cntSat));
    endtask

    // Raise reset between edges and check everything clears at once
    task automatic doReset();
        #2;
        rst = 1'b1;
        #1;
        modelReset();
        checkAll();
        checkOutput("rst_stall_out", 64'(stall_out), 64'd0);
        #1;
        rst = 1'b0;
    endtask

    int satExp[5] = '{1, 2, 3, 3, 3};

    initial begin
        rst = 1'b0;
        modelReset();
        applyStimulus(2'b00, 3'b000, 4'b0000, 5'd0, 5'd0, 5'd0, 1'b0, 32'd0);

        // Directed table
        vecs[0] = mkVec(2'b10, 3'b000, 4'b1100, 5'd1, 5'd2, 1'b0, 32'h11,
                        1'b0, 1'b1, 2'b10, 3'b000, 4'b1100, 32'h11, 0);
        vecs[1] = mkVec(2'b11, 3'b010, 4'b0001, 5'd9, 5'd8, 1'b0, 32'h20,
                        1'b0, 1'b1, 2'b11, 3'b010, 4'b0001, 32'h20, 0);
        vecs[2] = mkVec(2'b10, 3'b000, 4'b1100, 5'd8, 5'd5, 1'b0, 32'h33,
                        1'b1, 1'b0, 2'b00, 3'b000, 4'b0000, 32'h33, 1);
        vecs[3] = mkVec(2'b10, 3'b000, 4'b1100, 5'd8, 5'd5, 1'b0, 32'h33,
                        1'b0, 1'b1, 2'b10, 3'b000, 4'b1100, 32'h33, 1);
        vecs[4] = mkVec(2'b11, 3'b010, 4'b0001, 5'd3, 5'd0, 1'b0, 32'h44,
                        1'b0, 1'b1, 2'b11, 3'b010, 4'b0001, 32'h44, 1);
        vecs[5] = mkVec(2'b10, 3'b000, 4'b1100, 5'd0, 5'd0, 1'b0, 32'h55,
                        1'b0, 1'b1, 2'b10, 3'b000, 4'b1100, 32'h55, 1);
        vecs[6] = mkVec(2'b11, 3'b010, 4'b0001, 5'd2, 5'd7, 1'b0, 32'h66,
                        1'b0, 1'b1, 2'b11, 3'b010, 4'b0001, 32'h66, 1);
        vecs[7] = mkVec(2'b10, 3'b000, 4'b1100, 5'd7, 5'd1, 1'b1, 32'h77,
                        1'b0, 1'b0, 2'b00, 3'b000, 4'b0000, 32'h00, 1);
        vecs[8] = mkVec(2'b10, 3'b000, 4'b1100, 5'd1, 5'd7, 1'b0, 32'h88,
                        1'b0, 1'b1, 2'b10, 3'b000, 4'b1100, 32'h88, 1);

        @(posedge clk);
        #1;
        doReset();

        for (int i = 0; i < 9; i++) begin
            applyStimulus(vecs[i].wb, vecs[i].m, vecs[i].ex, vecs[i].rs,
                          vecs[i].rt, 5'd3, vecs[i].fl, vecs[i].rd1);
            #1;
            checkOutput($sformatf("v%0d_stall", i), 64'(stall_out), 64'(vecs[i].expStall));
            stepClock();
            checkOutput($sformatf("v%0d_valid", i), 64'(valid_out), 64'(vecs[i].expValid));
            checkOutput($sformatf("v%0d_wb", i),    64'(wb_out),    64'(vecs[i].expWb));
            checkOutput($sformatf("v%0d_m", i),     64'(m_out),     64'(vecs[i].expM));
            checkOutput($sformatf("v%0d_ex", i),    64'(ex_out),    64'(vecs[i].expEx));
            checkOutput($sformatf("v%0d_rd1", i),   64'(rd1_out),   64'(vecs[i].expRd1));
            checkOutput($sformatf("v%0d_cnt", i),   64'(stall_cnt), 64'(vecs[i].expCnt));
            checkOutput($sformatf("v%0d_regdst", i), 64'(reg_dst),  64'(vecs[i].expEx[3]));
            checkOutput($sformatf("v%0d_aluop", i), 64'(alu_op),    64'(vecs[i].expEx[2:1]));
            checkOutput($sformatf("v%0d_alusrc", i), 64'(alu_src),  64'(vecs[i].expEx[0]));
            checkOutput($sformatf("v%0d_stall_after", i), 64'(stall_out), 64'(modelStall()));
        end

        // Reset in the middle of a stall drops stall_out immediately
        doReset();
        applyStimulus(2'b11, 3'b010, 4'b0001, 5'd1, 5'd6, 5'd0, 1'b0, 32'h1);
        #1;
        stepClock();
        applyStimulus(2'b10, 3'b000, 4'b1100, 5'd2, 5'd6, 5'd4, 1'b0, 32'h2);
        #1;
        checkOutput("midstall_stall_on", 64'(stall_out), 64'd1);
        doReset();
        checkOutput("midstall_stall_off", 64'(stall_out), 64'd0);
        checkOutput("midstall_valid", 64'(valid_out), 64'd0);

        // Five back-to-back load-use stalls; the CW=2 counter must stick at 3
        for (int k = 0; k < 5; k++) begin
            applyStimulus(2'b11, 3'b010, 4'b0001, 5'd1, 5'd4, 5'd0, 1'b0, 32'h10);
            #1;
            stepClock();
            applyStimulus(2'b10, 3'b000, 4'b1100, 5'd4, 5'd2, 5'd5, 1'b0, 32'h20);
            #1;
            checkOutput($sformatf("sat%0d_stall", k), 64'(s_stall_out), 64'd1);
            stepClock();
            checkOutput($sformatf("sat%0d_cnt", k), 64'(s_stall_cnt), 64'(satExp[k]));
            checkOutput($sformatf("sat%0d_cnt16", k), 64'(stall_cnt), 64'(k + 1));
        end

        // Randomized traffic against the model; small specifier range so
        // hazards, $zero loads and flush collisions all occur regularly.
        doReset();
        for (int n = 0; n < 300; n++) begin
            applyStimulus(2'($urandom), ($urandom_range(0, 1) == 1) ? 3'b010 : 3'($urandom),
                          4'($urandom), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                          5'($urandom), ($urandom_range(0, 7) == 0), $urandom);
            #1;
            checkOutput("rnd_stall", 64'(stall_out), 64'(modelStall()));
            stepClock();
            checkAll();
            if ($urandom_range(0, 59) == 0) begin
                doReset();
            end
        end

        $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
        $finish;
    end

endmodule
